gol_sequencer: RTL and testbench
================================

# gol_sequencer

Run-control sequencer for the 8×8 Game of Life board. It turns debounced user commands (load, run/pause, single-step, speed) into a pattern index for the pattern loader, a board-load strobe for the board register, and a req/ack generation handshake to the next-generation engine. It sits between the button/switch front end and the board datapath, and keeps a generation counter for the display.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: base generation period in clk cycles at `speed`=0; must be ≥ 2.
- `CNT_W`, default 28: tick counter width; must hold `TICK_DIV<<3`.

Ports:
- `clk`: in, 1. System clock; all logic is on the rising edge.
- `rst`: in, 1. Reset, synchronous, active-low.
- `pattern_sel`: in, 4. Pattern chosen on the switches.
- `load_btn`: in, 1. Single-cycle pulse (debounced upstream); loads `pattern_sel`.
- `run_btn`: in, 1. Single-cycle pulse; toggles run/pause.
- `step_btn`: in, 1. Single-cycle pulse; advances one generation while paused.
- `speed`: in, 2. Period = `TICK_DIV << speed` cycles; sampled on entry to RUNNING.
- `gen_ack`: in, 1. Engine has finished the requested generation.
- `board_empty`: in, 1. Board has no live cells; valid whenever `gen_ack`=1.
- `pattern_idx`: out, 4. Registered index sent to the pattern loader.
- `board_load`: out, 1. One-cycle strobe; the board captures the loader output.
- `gen_req`: out, 1. Generation request to the engine.
- `running`: out, 1. High in RUNNING, and in STEP when the step came from RUNNING.
- `halted`: out, 1. Auto-stop occurred (only when `GOL_AUTOSTOP_EN` is defined).
- `gen_count`: out, 16. Generations completed since the last load.

## Operation
- States: IDLE, LOAD_WAIT, LOAD_COMMIT, PAUSED, RUNNING, STEP.
- Reset (`rst`=0 at an edge):
  - State goes to IDLE.
  - Every output is 0: `pattern_idx`, `board_load`, `gen_req`, `running`, `halted`, `gen_count`.
  - Tick counter, pending-load flag and pending-pause flag are cleared.
  - Reset during a handshake drops `gen_req` immediately; the engine is reset by the same `rst`.
- Command priority in one cycle: load > run > step.
- IDLE:
  - `load_btn` → LOAD_WAIT.
  - `run_btn` and `step_btn` are ignored.
- Accepting a load (from IDLE, PAUSED or RUNNING):
  - `pattern_idx` ← `pattern_sel`; go to LOAD_WAIT.
  - LOAD_WAIT (1 cycle) → LOAD_COMMIT.
  - LOAD_COMMIT (1 cycle): `board_load`=1, `gen_count`←0, `halted`←0, then PAUSED.
  - A load always ends in PAUSED.
  - `pattern_sel`=0 is legal and loads an empty board.
- PAUSED:
  - `run_btn` → RUNNING with tick counter 0.
  - `step_btn` → STEP with return target PAUSED.
- RUNNING:
  - Tick counter increments each cycle.
  - At count P−1 (P = `TICK_DIV<<speed`) → STEP with return target RUNNING.
  - `run_btn` → PAUSED.
- STEP:
  - `gen_req`=1 until the cycle `gen_ack` is sampled 1.
  - On that edge: `gen_req`←0, `gen_count`←`gen_count`+1 (wraps 0xFFFF→0), go to the return target.
  - Tick counter restarts at 0 when re-entering RUNNING.
- Commands during STEP; the handshake is never aborted except by reset:
  - `load_btn` sets pending-load with `pattern_idx` latched now. After ack, go to LOAD_WAIT instead of the return target.
  - `run_btn` toggles pending-pause. If set at ack, the return target becomes PAUSED.
  - `step_btn` is ignored.
- Commands during LOAD_WAIT and LOAD_COMMIT are ignored.
- `gen_ack` outside STEP is ignored.

## Timing
- Load latency (`load_btn` sampled at edge E0):
  - `pattern_idx` valid after E0.
  - Loader output valid after E1.
  - `board_load`=1 between E1 and E2.
  - PAUSED after E2.
- Run-to-first-request latency: `gen_req` rises P edges after the edge that sampled `run_btn`.
- Period between requests in RUNNING: exactly P + (ack latency in cycles) + 1.
- `gen_req` falls on the edge that samples `gen_ack`=1. An ack held for several cycles counts once.
- Every output is registered; no combinational path from input to output.

## Configuration
- `GOL_AUTOSTOP_EN` defined:
  - On an ack with `board_empty`=1 and return target RUNNING, go to PAUSED and set `halted`=1.
  - `halted` clears on load or on `run_btn` in PAUSED.
  - Pending-load still takes precedence.
- `GOL_AUTOSTOP_EN` undefined:
  - `board_empty` is ignored.
  - `halted` is tied to 0.
  - RUNNING continues indefinitely.

## Test plan
- Reset, then `load_btn` with `pattern_sel`=4'h3 → `pattern_idx`=3 next cycle, `board_load` pulses exactly 1 cycle two edges after the press, state PAUSED, `gen_count`=0.
- `TICK_DIV`=4, `speed`=1, `run_btn`, engine acks 2 cycles after each req → `gen_req` rises 8 edges after the run press, then every 11 cycles; `gen_count` reads 1, 2, 3.
- PAUSED, `step_btn` three times → exactly 3 requests, `gen_count`=3, `running`=0 throughout.
- `load_btn` (`pattern_sel`=4'h9) while `gen_req`=1 → req held until ack, `gen_count` increments, then `board_load` pulses, `gen_count`=0, PAUSED, `pattern_idx`=9.
- With `GOL_AUTOSTOP_EN` defined, running, ack with `board_empty`=1 → PAUSED, `halted`=1, no further `gen_req`. Without the macro, requests continue and `halted`=0.
- `rst`=0 while `gen_req`=1 → next edge all outputs 0, state IDLE; `run_btn` afterwards produces no `gen_req`.

Source files
------------

// File: rtl/gol_sequencer.sv
// -----------------------------------------------------------------------------
// gol_sequencer
//
// Run-control sequencer for the 8x8 Game of Life board. Debounced user
// commands (load, run/pause, single-step, speed) become a pattern index for
// the pattern loader, a one-cycle board-load strobe, and a req/ack handshake
// to the next-generation engine. A 16-bit generation counter is kept for the
// display.
//
// Parameters:
//   TICK_DIV    - base generation period in clk cycles at speed=0 (>= 2)
//   CNT_W       - tick counter width; must hold TICK_DIV<<3
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous, active-low reset
//   pattern_sel - pattern chosen on the switches
//   load_btn    - single-cycle pulse, load pattern_sel
//   run_btn     - single-cycle pulse, toggle run/pause
//   step_btn    - single-cycle pulse, one generation while paused
//   speed       - period = TICK_DIV << speed, sampled on entry to RUNNING
//   gen_ack     - engine finished the requested generation
//   board_empty - board has no live cells (valid with gen_ack)
//   pattern_idx - registered index to the pattern loader
//   board_load  - one-cycle strobe, board captures loader output
//   gen_req     - generation request to the engine
//   running     - RUNNING, or STEP entered from RUNNING
//   halted      - auto-stop occurred
//   gen_count   - generations completed since the last load
//
// Optional feature: define GOL_AUTOSTOP_EN to pause automatically when a
// generation produced while running leaves the board empty.
// -----------------------------------------------------------------------------
module gol_sequencer #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pattern_sel,
    input  logic        load_btn,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic [1:0]  speed,
    input  logic        gen_ack,
    input  logic        board_empty,
    output logic [3:0]  pattern_idx,
    output logic        board_load,
    output logic        gen_req,
    output logic        running,
    output logic        halted,
    output logic [15:0] gen_count
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD_WAIT   = 3'd1,
        S_LOAD_COMMIT = 3'd2,
        S_PAUSED      = 3'd3,
        S_RUNNING     = 3'd4,
        S_STEP        = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r,       state_n;
    logic [3:0]        pattern_idx_r, pattern_idx_n;
    logic              board_load_r,  board_load_n;
    logic              gen_req_r,     gen_req_n;
    logic              running_r,     running_n;
    logic              halted_r,      halted_n;
    logic [15:0]       gen_count_r,   gen_count_n;
    logic [CNT_W-1:0]  tick_r,        tick_n;
    logic [CNT_W-1:0]  period_m1_r,   period_m1_n;
    logic              ret_run_r,     ret_run_n;
    logic              pend_load_r,   pend_load_n;
    logic              pend_pause_r,  pend_pause_n;

    logic [CNT_W-1:0]  period_m1_s;
    logic              pend_load_s;
    logic              pend_pause_s;
    logic              autostop_s;

    // Terminal tick count for the currently selected speed.
    assign period_m1_s = (CNT_W'(TICK_DIV) << speed) - CNT_ONE;

    // Load outranks run inside STEP, so a simultaneous run press is dropped.
    assign pend_load_s  = pend_load_r | load_btn;
    assign pend_pause_s = pend_pause_r ^ (run_btn & ~load_btn);

`ifdef GOL_AUTOSTOP_EN
    assign autostop_s = board_empty;
`else
    logic unused_board_empty_s;
    assign unused_board_empty_s = board_empty;
    assign autostop_s = 1'b0;
`endif

    // Next-state and next-output logic; every output is produced from here
    // and registered, so no input reaches an output combinationally.
    always_comb begin
        state_n       = state_r;
        pattern_idx_n = pattern_idx_r;
        board_load_n  = 1'b0;
        gen_req_n     = gen_req_r;
        halted_n      = halted_r;
        gen_count_n   = gen_count_r;
        tick_n        = tick_r;
        period_m1_n   = period_m1_r;
        ret_run_n     = ret_run_r;
        pend_load_n   = pend_load_r;
        pend_pause_n  = pend_pause_r;

        case (state_r)
            S_IDLE: begin
                if (load_btn) begin
                    state_n       = S_LOAD_WAIT;
                    pattern_idx_n = pattern_sel;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_LOAD_WAIT: begin
                // Loader output becomes valid now; strobe the board next cycle.
                state_n      = S_LOAD_COMMIT;
                board_load_n = 1'b1;
                gen_count_n  = 16'd0;
                halted_n     = 1'b0;
            end

            S_LOAD_COMMIT: begin
                state_n = S_PAUSED;
            end

            S_PAUSED: begin
                if (load_btn) begin
                    state_n       = S_LOAD_WAIT;
                    pattern_idx_n = pattern_sel;
                end else if (run_btn) begin
                    state_n     = S_RUNNING;
                    tick_n      = CNT_ZERO;
                    period_m1_n = period_m1_s;
                    halted_n    = 1'b0;
                end else if (step_btn) begin
                    state_n      = S_STEP;
                    gen_req_n    = 1'b1;
                    ret_run_n    = 1'b0;
                    pend_load_n  = 1'b0;
                    pend_pause_n = 1'b0;
                end else begin
                    state_n = S_PAUSED;
                end
            end

            S_RUNNING: begin
                if (load_btn) begin
                    state_n       = S_LOAD_WAIT;
                    pattern_idx_n = pattern_sel;
                end else if (run_btn) begin
                    state_n = S_PAUSED;
                end else if (tick_r == period_m1_r) begin
                    state_n      = S_STEP;
                    gen_req_n    = 1'b1;
                    ret_run_n    = 1'b1;
                    pend_load_n  = 1'b0;
                    pend_pause_n = 1'b0;
                end else begin
                    tick_n = tick_r + CNT_ONE;
                end
            end

            S_STEP: begin
                // Commands only arm flags; the handshake always completes.
                pend_load_n  = pend_load_s;
                pend_pause_n = pend_pause_s;
                if (load_btn) begin
                    pattern_idx_n = pattern_sel;
                end else begin
                    pattern_idx_n = pattern_idx_r;
                end

                if (gen_ack) begin
                    gen_req_n    = 1'b0;
                    gen_count_n  = gen_count_r + 16'd1;
                    pend_load_n  = 1'b0;
                    pend_pause_n = 1'b0;
                    if (pend_load_s) begin
                        state_n = S_LOAD_WAIT;
                    end else if (ret_run_r && !pend_pause_s) begin
                        if (autostop_s) begin
                            state_n  = S_PAUSED;
                            halted_n = 1'b1;
                        end else begin
                            state_n     = S_RUNNING;
                            tick_n      = CNT_ZERO;
                            period_m1_n = period_m1_s;
                        end
                    end else begin
                        state_n = S_PAUSED;
                    end
                end else begin
                    state_n = S_STEP;
                end
            end

            default: begin
                state_n      = S_IDLE;
                gen_req_n    = 1'b0;
                pend_load_n  = 1'b0;
                pend_pause_n = 1'b0;
            end
        endcase

        // A step taken from RUNNING keeps the run indicator lit.
        running_n = (state_n == S_RUNNING) || ((state_n == S_STEP) && ret_run_n);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            pattern_idx_r <= 4'd0;
            board_load_r  <= 1'b0;
            gen_req_r     <= 1'b0;
            running_r     <= 1'b0;
            halted_r      <= 1'b0;
            gen_count_r   <= 16'd0;
            tick_r        <= CNT_ZERO;
            period_m1_r   <= CNT_ZERO;
            ret_run_r     <= 1'b0;
            pend_load_r   <= 1'b0;
            pend_pause_r  <= 1'b0;
        end else begin
            state_r       <= state_n;
            pattern_idx_r <= pattern_idx_n;
            board_load_r  <= board_load_n;
            gen_req_r     <= gen_req_n;
            running_r     <= running_n;
            halted_r      <= halted_n;
            gen_count_r   <= gen_count_n;
            tick_r        <= tick_n;
            period_m1_r   <= period_m1_n;
            ret_run_r     <= ret_run_n;
            pend_load_r   <= pend_load_n;
            pend_pause_r  <= pend_pause_n;
        end
    end

    assign pattern_idx = pattern_idx_r;
    assign board_load  = board_load_r;
    assign gen_req     = gen_req_r;
    assign running     = running_r;
    assign halted      = halted_r;
    assign gen_count   = gen_count_r;

endmodule

// File: tb/tb_gol_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gol_sequencer
//
// Directed scenarios with literal expectations, then randomized commands,
// engine latencies, board_empty values and occasional resets. A behavioural
// model of the run-control rules predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_gol_sequencer;

    localparam int TD = 4;

`ifdef GOL_AUTOSTOP_EN
    localparam bit AUTOSTOP = 1'b1;
`else
    localparam bit AUTOSTOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  pattern_sel = 4'd0;
    logic        load_btn = 1'b0;
    logic        run_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        gen_ack = 1'b0;
    logic        board_empty = 1'b0;
    logic [3:0]  pattern_idx;
    logic        board_load;
    logic        gen_req;
    logic        running;
    logic        halted;
    logic [15:0] gen_count;

    int total = 0;
    int bad   = 0;

    gol_sequencer #(.TICK_DIV(TD), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .load_btn(load_btn),
        .run_btn(run_btn), .step_btn(step_btn), .speed(speed), .gen_ack(gen_ack),
        .board_empty(board_empty), .pattern_idx(pattern_idx), .board_load(board_load),
        .gen_req(gen_req), .running(running), .halted(halted), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_LOADING = 1, PH_PAUSED = 2, PH_RUNNING = 3, PH_GEN = 4;
    int          ph = PH_IDLE;
    int          load_cd = 0;
    int          left = 0;
    bit          from_run = 0, pl = 0, pp = 0;
    bit          model_ok = 0;
    logic [3:0]  e_pidx = 4'd0;
    bit          e_load = 0, e_req = 0, e_run = 0, e_halt = 0;
    logic [15:0] e_gcnt = 16'd0;

    task automatic start_load();
        ph = PH_LOADING; load_cd = 2; e_pidx = pattern_sel;
    endtask

    task automatic begin_run();
        ph = PH_RUNNING; left = TD << speed;
    endtask

    task automatic begin_gen(input bit fr);
        ph = PH_GEN; from_run = fr; pl = 0; pp = 0;
    endtask

    task automatic model_step();
        if (!rst) begin
            ph = PH_IDLE; e_pidx = 4'd0; e_load = 0; e_halt = 0; e_gcnt = 16'd0;
            left = 0; pl = 0; pp = 0; from_run = 0; model_ok = 1;
        end else begin
            e_load = 0;
            case (ph)
                PH_IDLE: if (load_btn) start_load();
                PH_LOADING: begin
                    if (load_cd == 2) begin
                        load_cd = 1; e_load = 1; e_gcnt = 16'd0; e_halt = 0;
                    end else ph = PH_PAUSED;
                end
                PH_PAUSED: begin
                    if (load_btn) start_load();
                    else if (run_btn) begin begin_run(); e_halt = 0; end
                    else if (step_btn) begin_gen(0);
                end
                PH_RUNNING: begin
                    if (load_btn) start_load();
                    else if (run_btn) ph = PH_PAUSED;
                    else begin
                        left--;
                        if (left == 0) begin_gen(1);
                    end
                end
                PH_GEN: begin
                    if (load_btn) begin pl = 1; e_pidx = pattern_sel; end
                    else if (run_btn) pp = !pp;
                    if (gen_ack) begin
                        e_gcnt = e_gcnt + 16'd1;
                        if (pl) begin ph = PH_LOADING; load_cd = 2; end
                        else if (from_run && !pp) begin
                            if (AUTOSTOP && board_empty) begin ph = PH_PAUSED; e_halt = 1; end
                            else begin_run();
                        end else ph = PH_PAUSED;
                    end
                end
                default: ph = PH_IDLE;
            endcase
        end
        e_req = (ph == PH_GEN);
        e_run = (ph == PH_RUNNING) || (ph == PH_GEN && from_run);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare DUT against model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("cmp_pattern_idx", pattern_idx, e_pidx);
            check("cmp_board_load", board_load, e_load);
            check("cmp_gen_req", gen_req, e_req);
            check("cmp_running", running, e_run);
            check("cmp_halted", halted, e_halt);
            check("cmp_gen_count", gen_count, e_gcnt);
        end
    end

    // ---------------- engine model ----------------
    int ack_lat = 2;
    int age = 0;
    int empty_mode = 0;     // 0: never empty, 1: always empty, 2: random
    bit spurious_en = 0;

    initial forever begin
        @(negedge clk);
        if (gen_req) begin
            age++;
            gen_ack = (age > ack_lat);
        end else begin
            age = 0;
            gen_ack = spurious_en && ($urandom_range(0, 7) == 0);
        end
        case (empty_mode)
            0: board_empty = 1'b0;
            1: board_empty = 1'b1;
            default: board_empty = ($urandom_range(0, 3) == 0);
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int which, input logic [3:0] sel);
        @(negedge clk);
        pattern_sel = sel;
        load_btn = (which == 0);
        run_btn  = (which == 1);
        step_btn = (which == 2);
        @(negedge clk);
        load_btn = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
    endtask

    task automatic wait_rise(output int n);
        logic prev;
        bit got;
        got = 0; prev = gen_req; n = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            n++;
            if (gen_req && !prev) got = 1;
            prev = gen_req;
        end
        check("wait_rise", got, 1);
    endtask

    task automatic wait_fall();
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!gen_req) got = 1;
        end
        check("wait_fall", got, 1);
    endtask

    int n;
    int rises;
    int hi;
    logic prev_req;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pattern_idx", pattern_idx, 0);
        check("rst_gen_req", gen_req, 0);
        check("rst_gen_count", gen_count, 0);
        check("rst_running", running, 0);
        rst = 1'b1;

        // Load pattern 3
        press(0, 4'h3);
        check("load_pidx", pattern_idx, 3);
        check("load_strobe_e1", board_load, 0);
        @(negedge clk);
        check("load_strobe_e2", board_load, 1);
        @(negedge clk);
        check("load_strobe_end", board_load, 0);
        check("load_gcnt", gen_count, 0);
        check("load_running", running, 0);

        // Run at speed 1: P = 8, engine ack latency makes period 11
        speed = 2'd1;
        ack_lat = 2;
        press(1, 4'h0);
        repeat (7) @(negedge clk);
        check("first_req_early", gen_req, 0);
        @(negedge clk);
        check("first_req_at_P", gen_req, 1);
        for (int g = 1; g <= 3; g++) begin
            wait_rise(n);
            check("run_period", n, 11);
            check("run_gcnt", gen_count, g);
        end

        // Pause during a request; handshake still completes
        press(1, 4'h0);
        wait_fall();
        repeat (2) @(negedge clk);
        check("pause_running", running, 0);
        check("pause_gcnt", gen_count, 4);

        // Reload, then three single steps
        press(0, 4'h5);
        repeat (3) @(negedge clk);
        check("reload_gcnt", gen_count, 0);
        for (int s = 0; s < 3; s++) begin
            press(2, 4'h0);
            check("step_req", gen_req, 1);
            check("step_running", running, 0);
            wait_fall();
            @(negedge clk);
        end
        check("step_gcnt", gen_count, 3);

        // Load while a request is outstanding
        ack_lat = 4;
        press(2, 4'h0);
        press(0, 4'h9);
        check("ldreq_pidx", pattern_idx, 9);
        check("ldreq_held", gen_req, 1);
        wait_fall();
        check("ldreq_gcnt_inc", gen_count, 4);
        check("ldreq_no_strobe_yet", board_load, 0);
        @(negedge clk);
        check("ldreq_strobe", board_load, 1);
        check("ldreq_gcnt_clr", gen_count, 0);
        @(negedge clk);
        check("ldreq_strobe_end", board_load, 0);
        check("ldreq_running", running, 0);
        ack_lat = 2;

        // Empty board while running
        empty_mode = 1;
        press(1, 4'h0);
        wait_rise(n);
        wait_fall();
        repeat (2) @(negedge clk);
        rises = 0;
        prev_req = gen_req;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gen_req && !prev_req) rises++;
            prev_req = gen_req;
        end
`ifdef GOL_AUTOSTOP_EN
        check("autostop_halted", halted, 1);
        check("autostop_running", running, 0);
        check("autostop_no_req", rises, 0);
        empty_mode = 0;
        press(2, 4'h0);
`else
        check("noauto_halted", halted, 0);
        check("noauto_continues", int'(rises > 3), 1);
        empty_mode = 0;
        if (!gen_req) wait_rise(n);
`endif

        // Reset during a handshake
        check("pre_rst_req", gen_req, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("hrst_req", gen_req, 0);
        check("hrst_running", running, 0);
        check("hrst_gcnt", gen_count, 0);
        check("hrst_pidx", pattern_idx, 0);
        check("hrst_board_load", board_load, 0);
        check("hrst_halted", halted, 0);
        press(1, 4'h0);
        press(2, 4'h0);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gen_req) hi++;
        end
        check("idle_no_req", hi, 0);

        // Randomized phase
        spurious_en = 1;
        empty_mode = 2;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 399) != 0);
            pattern_sel = 4'($urandom);
            load_btn    = ($urandom_range(0, 59) == 0);
            run_btn     = ($urandom_range(0, 24) == 0);
            step_btn    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom);
            if ($urandom_range(0, 99) == 0) ack_lat = $urandom_range(0, 3);
        end
        @(negedge clk);
        load_btn = 1'b0; run_btn = 1'b0; step_btn = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
